// File: rtl/q15_pkg.sv
// Shared definitions for the Q15 divider sharing logic: constants and FSM states.
package q15_pkg;

    localparam int DATA_W = 64;

    localparam logic [DATA_W-1:0] Q15_NAN = 64'h8000_0000_0000_0000;
    localparam logic [DATA_W-1:0] Q15_ONE = 64'h0000_0000_0000_8000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } q15_arb_state_t;

endpackage

// File: rtl/q15_div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// the previous winner, wrapping around modulo N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any
);

    logic found;

    // Scan N positions starting one past the last winner; keep the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/q15_div_arbiter.sv
// Shares one Q15 divider among NREQ requesters: round-robin accept, launch,
// hold operands while the divider works, then return a buffered response.
module q15_div_arbiter
    import q15_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDW-1:0]           resp_id,
    output logic signed [DATA_W-1:0] resp_res,
    output logic                     div_launch,
    output logic signed [DATA_W-1:0] div_a,
    output logic signed [DATA_W-1:0] div_b,
    input  logic                     div_busy,
    input  logic signed [DATA_W-1:0] div_res
);

    q15_arb_state_t  state;
    logic [IDW-1:0]  last;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            any;
    logic [IDW+5:0]  sel_base;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req      (req_valid),
        .last     (last),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    // Bit offset of the granted requester's 64-bit operand slot.
    assign sel_base = {grant_id, 6'd0};

    // Accept is only offered from IDLE, and never while reset is held, so a
    // request pending across reset is not acknowledged until reset releases.
    assign req_ready  = (state == ST_IDLE && reset) ? grant : '0;
    assign div_launch = (state == ST_LAUNCH);

    // Sequencer: accept -> launch -> settle -> wait for divider -> hold response.
    // div_a/div_b are written only on IDLE exit, so they stay stable until RESP exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last       <= IDW'(NREQ - 1);
            div_a      <= '0;
            div_b      <= '0;
            resp_id    <= '0;
            resp_res   <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        div_a   <= req_a[sel_base +: DATA_W];
                        div_b   <= req_b[sel_base +: DATA_W];
                        resp_id <= grant_id;
                        last    <= grant_id;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state <= ST_SETTLE;
                // Dead cycle gives the divider time to raise busy after launch.
                ST_SETTLE: state <= ST_WAIT;
                ST_WAIT: begin
                    // Fast-path results (busy never rises) are captured here too.
                    if (!div_busy) begin
                        resp_res   <= div_res;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q15_div_arbiter.sv
// Bench for q15_div_arbiter with a behavioural divider and round-robin model.
module tb_q15_div_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a;
    logic [NREQ*64-1:0]   req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [63:0]          resp_res;
    logic                 div_launch;
    logic [63:0]          div_a;
    logic [63:0]          div_b;
    logic                 div_busy;
    logic [63:0]          div_res;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int launch_cnt = 0;
    int busy_cnt   = 0;
    int lat        = 0;
    int last_m     = NREQ - 1;

    logic [63:0] opa [NREQ];
    logic [63:0] opb [NREQ];

    q15_div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_res   (resp_res),
        .div_launch (div_launch),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_res    (div_res)
    );

    always #5 clk = ~clk;

    // Q15 quotient with the divider's zero/infinity fast paths.
    function automatic logic [63:0] q15_div(input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 64'd0) return 64'h8000_0000_0000_0000;
        if (a == 64'd0) return 64'd0;
        return 64'((sa * 64'sd32768) / sb);
    endfunction

    // Requester picked after the previous winner, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last_m + k) % NREQ;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (div_launch) launch_cnt <= launch_cnt + 1;

    // Divider model: busy from the settle cycle for lat+1 cycles (none when lat==0);
    // the result bus carries junk while busy so an early capture is visible.
    always @(posedge clk or negedge reset) begin
        if (!reset)          busy_cnt <= 0;
        else if (div_launch) busy_cnt <= (lat > 0) ? lat + 1 : 0;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign div_busy = (busy_cnt > 0);
    assign div_res  = div_busy ? 64'hBAD0_BAD0_BAD0_BAD0 : q15_div(div_a, div_b);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [63:0] a, input logic [63:0] b);
        opa[id] = a;
        opb[id] = b;
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
    endtask

    // Call while the DUT is idle with requests already driven (between edges).
    // Checks accept, launch, latency 4+L, result, id, optional backpressure hold,
    // and returns one cycle after the response handshake.
    task automatic run_one(input int exp_id, input int L, input int bp, input logic [63:0] exp_res);
        int t0;
        int start_l;
        int n;
        lat     = L;
        start_l = launch_cnt;
        #1;
        chk("grant", 64'(req_ready), 64'(1 << exp_id));
        t0     = cyc;
        last_m = exp_id;
        @(negedge clk);
        req_valid[exp_id] = 1'b0;
        #1;
        chk("launch", 64'(div_launch), 64'd1);
        chk("div_a", div_a, opa[exp_id]);
        chk("div_b", div_b, opb[exp_id]);
        chk("ready_inflight", 64'(req_ready), 64'd0);
        n = 0;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(cyc - t0), 64'(4 + L));
        chk("resp_res", resp_res, exp_res);
        chk("resp_id", 64'(resp_id), 64'(exp_id));
        chk("launch_count", 64'(launch_cnt - start_l), 64'd1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_res", resp_res, exp_res);
            chk("bp_id", 64'(resp_id), 64'(exp_id));
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_div_a", div_a, opa[exp_id]);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        chk("resp_clear", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] m;
        int e;
        int L;
        longint ra;
        longint rb;

        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_res", resp_res, 64'd0);
        chk("rst_launch", 64'(div_launch), 64'd0);
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_div_b", div_b, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fairness: all four requesters continuously valid -> 0,1,2,3,0,1,2,3.
        for (int k = 0; k < NREQ; k++) set_ops(k, 64'((k + 1) << 16), 64'h10000);
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            run_one(n % 4, 1, 0, 64'((n + 1) << 15));
            set_ops(n % 4, 64'((n + 5) << 16), 64'h10000);
            req_valid[n % 4] = 1'b1;
        end
        req_valid = '0;

        // Single request from requester 2: 6.0 / 2.0 = 3.0.
        set_ops(2, 64'h30000, 64'h10000);
        req_valid = 4'b0100;
        run_one(2, 3, 0, 64'h18000);

        // Fast paths: divide by zero -> NaN, zero dividend -> 0.
        set_ops(1, 64'h10000, 64'h0);
        req_valid = 4'b0010;
        run_one(1, 0, 0, 64'h8000_0000_0000_0000);
        set_ops(3, 64'h0, 64'h10000);
        req_valid = 4'b1000;
        run_one(3, 0, 0, 64'h0);

        // Negative operand: -1.0 / 2.0 = -0.5.
        set_ops(0, 64'hFFFF_FFFF_FFFF_8000, 64'h10000);
        req_valid = 4'b0001;
        run_one(0, 2, 0, 64'hFFFF_FFFF_FFFF_C000);

        // Backpressure with other requests pending, then immediate next grant.
        set_ops(0, 64'h20000, 64'h10000);
        set_ops(1, 64'h50000, 64'h20000);
        set_ops(3, 64'h70000, 64'hFFFF_FFFF_FFFF_0000);
        req_valid = 4'b1011;
        e = rr_pick(req_valid);
        run_one(e, 2, 10, q15_div(opa[e], opb[e]));
        e = rr_pick(req_valid);
        run_one(e, 1, 0, q15_div(opa[e], opb[e]));
        req_valid = '0;

        // Randomized requests checked against the reference model.
        for (int n = 0; n < 12; n++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) begin
                ra = longint'($urandom_range(0, 1 << 30)) - (64'sd1 <<< 29);
                rb = longint'($urandom_range(0, 1 << 21)) - (64'sd1 <<< 20);
                if ($urandom_range(0, 7) == 0) ra = 0;
                if ($urandom_range(0, 5) == 0) rb = 0;
                set_ops(k, 64'(ra), 64'(rb));
            end
            req_valid = m;
            e = rr_pick(m);
            L = (opa[e] == 64'd0 || opb[e] == 64'd0) ? 0 : int'($urandom_range(0, 5));
            run_one(e, L, 0, q15_div(opa[e], opb[e]));
        end
        req_valid = '0;

        // Reset while the divider is busy: everything drops, requester 0 wins afterwards.
        set_ops(1, 64'h40000, 64'h10000);
        req_valid = 4'b0010;
        lat = 20;
        #1;
        chk("mid_grant", 64'(req_ready), 64'(1 << rr_pick(4'b0010)));
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        set_ops(0, 64'h60000, 64'h30000);
        set_ops(2, 64'h10000, 64'h40000);
        req_valid = 4'b0101;
        reset = 1'b0;
        #1;
        chk("mr_ready", 64'(req_ready), 64'd0);
        chk("mr_resp_valid", 64'(resp_valid), 64'd0);
        chk("mr_resp_id", 64'(resp_id), 64'd0);
        chk("mr_resp_res", resp_res, 64'd0);
        chk("mr_launch", 64'(div_launch), 64'd0);
        chk("mr_div_a", div_a, 64'd0);
        chk("mr_div_b", div_b, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        last_m = NREQ - 1;
        run_one(0, 1, 0, 64'h10000);
        run_one(2, 0, 0, 64'h2000);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("idle_no_resp", 64'(resp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
